// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port 32-bit memory among three requesters:
//   IF - instruction fetch (read only)
//   D  - CPU data load/store
//   H  - external host/debug port (reads/writes any address, core keeps running)
//
// One access at a time: IDLE -> ACCESS (MEM_LAT cycles) -> RESP (ack) -> IDLE.
// Normal priority is D > IF > H. A host that has waited HOST_MAX_WAIT cycles
// is promoted to H > D > IF so debug traffic cannot be starved by the core.
//
// Ports:
//   Clk, Reset               clock (rising edge), async active-low reset
//   if_req/if_addr/if_ack    fetch request, address, one-cycle completion
//   d_req/d_we/d_be/d_addr/
//   d_wdata/d_ack            data request fields and one-cycle completion
//   h_req/h_we/h_be/h_addr/
//   h_wdata/h_ack            host request fields and one-cycle completion
//   rdata                    read data, valid while any ack is high
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata      memory side; mem_rdata sampled MEM_LAT cycles
//                            after the mem_en cycle began
//   busy                     high in ACCESS and RESP
//   owner                    0 = IF, 1 = D, 2 = H, 3 = none
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int MEM_LAT       = 1,   // 1..15
    parameter int HOST_MAX_WAIT = 8    // 1..255
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [3:0]        h_be,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [31:0]       h_wdata,
    output logic              h_ack,

    output logic [31:0]       rdata,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic              busy,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] OWN_IF   = 2'd0;
    localparam logic [1:0] OWN_D    = 2'd1;
    localparam logic [1:0] OWN_H    = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [7:0] HMAX = 8'(HOST_MAX_WAIT);

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic [7:0]          hwait;
    logic [1:0]          owner_q;
    logic                lat_we;
    logic [3:0]          lat_be;
    logic [ADDR_W-1:0]   lat_addr;
    logic [31:0]         lat_wdata;
    logic [31:0]         rdata_q;

    logic                any_req;
    logic                host_boost;
    logic [1:0]          winner;

    // ------------------------------------------------------------------
    // Winner selection, evaluated every cycle but only used in IDLE.
    // ------------------------------------------------------------------
    assign any_req    = if_req | d_req | h_req;
    assign host_boost = h_req && (hwait == HMAX);

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first
        // so that no path through the block leaves it unassigned (no latch).
        winner = OWN_NONE;
        if (host_boost)  winner = OWN_H;
        else if (d_req)  winner = OWN_D;
        else if (if_req) winner = OWN_IF;
        else if (h_req)  winner = OWN_H;
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        h_ack     = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) state_nxt = ACCESS;
            end
            ACCESS: begin
                busy = 1'b1;
                // Strobe only in the first ACCESS cycle; the memory is
                // expected to pipeline the read itself.
                if (cnt == 4'd1) begin
                    mem_en = 1'b1;
                    mem_we = lat_be;
                end
                if (cnt == LAT) state_nxt = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                if_ack    = (owner_q == OWN_IF);
                d_ack     = (owner_q == OWN_D);
                h_ack     = (owner_q == OWN_H);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched request, latency counter, read data, host wait.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: the latched request and read data are reset as well, so the
        // memory port shows zeros (not stale addresses) right after reset.
        if (!Reset) begin
            cnt       <= 4'd0;
            hwait     <= 8'd0;
            owner_q   <= OWN_NONE;
            lat_we    <= 1'b0;
            lat_be    <= 4'b0000;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= winner;
                        cnt     <= 4'd1;
                        case (winner)
                            OWN_D: begin
                                lat_we    <= d_we;
                                lat_be    <= d_we ? d_be : 4'b0000;
                                lat_addr  <= d_addr;
                                lat_wdata <= d_wdata;
                            end
                            OWN_H: begin
                                lat_we    <= h_we;
                                lat_be    <= h_we ? h_be : 4'b0000;
                                lat_addr  <= h_addr;
                                lat_wdata <= h_wdata;
                            end
                            default: begin
                                lat_we    <= 1'b0;
                                lat_be    <= 4'b0000;
                                lat_addr  <= if_addr;
                                lat_wdata <= 32'd0;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    if (cnt == LAT) begin
                        // Writes (including the be = 0 no-op write) leave
                        // rdata untouched.
                        if (!lat_we) rdata_q <= mem_rdata;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    owner_q <= OWN_NONE;
                    cnt     <= 4'd0;
                end
                default: ;
            endcase

            // Host starvation guard: counts cycles the host is kept waiting.
            if (!h_req)
                hwait <= 8'd0;
            else if (state == IDLE && winner == OWN_H)
                hwait <= 8'd0;
            else if (owner_q != OWN_H && hwait != HMAX)
                hwait <= hwait + 8'd1;
        end
    end

    assign owner     = owner_q;
    assign rdata     = rdata_q;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances share clock and reset:
//   u_dut1 - MEM_LAT = 1, used for the single fetch read
//   u_dut3 - MEM_LAT = 3, used for writes, arbitration, starvation, reset
// Each instance has a small behavioural memory whose read data follows
// mem_addr combinationally and whose writes land on the rising edge while
// mem_en is high.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- MEM_LAT = 1 instance ----------------
    logic        a_if_req  = 1'b0;
    logic [15:0] a_if_addr = 16'h0;
    logic        a_if_ack, a_d_ack, a_h_ack, a_mem_en, a_busy;
    logic [3:0]  a_mem_we;
    logic [15:0] a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata, a_rdata;
    logic [1:0]  a_owner;
    logic [31:0] mem1 [0:63];

    assign a_mem_rdata = mem1[a_mem_addr[7:2]];

    mem_port_arbiter #(.ADDR_W(16), .MEM_LAT(1), .HOST_MAX_WAIT(8)) u_dut1 (
        .Clk(clk), .Reset(rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack),
        .d_req(1'b0), .d_we(1'b0), .d_be(4'b0000), .d_addr(16'h0),
        .d_wdata(32'h0), .d_ack(a_d_ack),
        .h_req(1'b0), .h_we(1'b0), .h_be(4'b0000), .h_addr(16'h0),
        .h_wdata(32'h0), .h_ack(a_h_ack),
        .rdata(a_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .owner(a_owner)
    );

    // ---------------- MEM_LAT = 3 instance ----------------
    logic        if_req = 1'b0, d_req = 1'b0, h_req = 1'b0;
    logic        d_we = 1'b0, h_we = 1'b0;
    logic [3:0]  d_be = 4'h0, h_be = 4'h0;
    logic [15:0] if_addr = 16'h0, d_addr = 16'h0, h_addr = 16'h0;
    logic [31:0] d_wdata = 32'h0, h_wdata = 32'h0;
    logic        if_ack, d_ack, h_ack, mem_en, busy;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, rdata;
    logic [1:0]  owner;
    logic [31:0] mem3 [0:63];

    assign mem_rdata = mem3[mem_addr[7:2]];

    mem_port_arbiter #(.ADDR_W(16), .MEM_LAT(3), .HOST_MAX_WAIT(8)) u_dut3 (
        .Clk(clk), .Reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack),
        .h_req(h_req), .h_we(h_we), .h_be(h_be), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_ack(h_ack),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    // Memory models: one process owns both arrays.
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem1[4]  = 32'h2008000A;   // 0x0010
        mem3[8]  = 32'hA0A0A0A0;   // 0x0020
        mem3[12] = 32'hB1B1B1B1;   // 0x0030
        mem3[16] = 32'hC2C2C2C2;   // 0x0040
        mem3[20] = 32'h11223344;   // 0x0050
        forever begin
            @(posedge clk);
            if (mem_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem3[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits up to maxc falling edges for the selected ack (0 IF, 1 D, 2 H)
    // on u_dut3; cyc is the falling edge index it was seen on, -1 on timeout.
    task automatic wait_ack(input int sel, input int maxc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if ((sel == 0 && if_ack) || (sel == 1 && d_ack) || (sel == 2 && h_ack)) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc, dc, ic, dn, inn, hc;
        logic [31:0] dr, ir, hr;
        logic [1:0]  own5;
        logic [7:0]  hw;

        // ---------------- Reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_owner",    32'(owner),     32'd3);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_acks",     32'({if_ack, d_ack, h_ack}), 32'd0);
        check("rst_mem_en",   32'(mem_en),    32'd0);
        check("rst_mem_we",   32'(mem_we),    32'd0);
        check("rst_mem_addr", 32'(mem_addr),  32'd0);
        check("rst_rdata",    rdata,          32'd0);
        check("rst_owner1",   32'(a_owner),   32'd3);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- IF read, MEM_LAT = 1 ----------------
        a_if_req  = 1'b1;
        a_if_addr = 16'h0010;
        @(negedge clk);
        check("if1_mem_en",   32'(a_mem_en),   32'd1);
        check("if1_mem_addr", 32'(a_mem_addr), 32'h0010);
        check("if1_owner",    32'(a_owner),    32'd0);
        check("if1_ack_early",32'(a_if_ack),   32'd0);
        @(negedge clk);
        check("if1_mem_en_off", 32'(a_mem_en), 32'd0);
        check("if1_ack",        32'(a_if_ack), 32'd1);
        check("if1_rdata",      a_rdata,       32'h2008000A);
        a_if_req = 1'b0;
        @(negedge clk);
        check("if1_owner_idle", 32'(a_owner),  32'd3);
        check("if1_ack_once",   32'(a_if_ack), 32'd0);

        // ---------------- D write to 0xFFEC, MEM_LAT = 3 ----------------
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 16'hFFEC; d_wdata = 32'h12345678;
        @(negedge clk);
        check("dw_mem_en_c1",   32'(mem_en),   32'd1);
        check("dw_mem_we_c1",   32'(mem_we),   32'hF);
        check("dw_mem_addr_c1", 32'(mem_addr), 32'hFFEC);
        check("dw_mem_wdata",   mem_wdata,     32'h12345678);
        @(negedge clk);
        check("dw_mem_we_c2",   32'(mem_we),   32'h0);
        check("dw_mem_addr_c2", 32'(mem_addr), 32'hFFEC);
        @(negedge clk);
        check("dw_mem_addr_c3", 32'(mem_addr), 32'hFFEC);
        check("dw_ack_early",   32'(d_ack),    32'd0);
        @(negedge clk);
        check("dw_ack",         32'(d_ack),    32'd1);
        check("dw_rdata_kept",  rdata,         32'd0);
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 16'hFFEC;
        wait_ack(2, 10, cyc);
        check("hr_latency", 32'(cyc), 32'd4);
        check("hr_rdata",   rdata,    32'h12345678);
        h_req = 1'b0;
        @(negedge clk);

        // ---------------- Simultaneous IF and D ----------------
        if_req = 1'b1; if_addr = 16'h0030;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        dc = -1; ic = -1; dn = 0; inn = 0; dr = 32'h0; ir = 32'h0; own5 = 2'd0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 5) own5 = owner;
            if (d_ack)  begin dc = i; dn++;  dr = rdata; d_req  = 1'b0; end
            if (if_ack) begin ic = i; inn++; ir = rdata; if_req = 1'b0; end
        end
        check("sim_d_cycle",  32'(dc),   32'd4);
        check("sim_d_rdata",  dr,        32'hA0A0A0A0);
        check("sim_bubble",   32'(own5), 32'd3);
        check("sim_if_cycle", 32'(ic),   32'd9);
        check("sim_if_rdata", ir,        32'hB1B1B1B1);
        check("sim_acks",     32'({dn[7:0], inn[7:0]}), 32'h0101);

        // ---------------- Host starvation guard ----------------
        d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        if_req = 1'b1; if_addr = 16'h0030;
        h_req  = 1'b1; h_we = 1'b0; h_addr = 16'h0040;
        hc = -1; dn = 0; inn = 0; hr = 32'h0; hw = 8'hFF;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (d_ack)  dn++;
            if (if_ack) inn++;
            if (h_ack) begin
                hc = i; hr = rdata; hw = u_dut3.hwait;
                d_req = 1'b0; if_req = 1'b0; h_req = 1'b0;
                break;
            end
        end
        check("starve_h_cycle", 32'(hc),  32'd14);
        check("starve_d_acks",  32'(dn),  32'd2);
        check("starve_if_acks", 32'(inn), 32'd0);
        check("starve_h_rdata", hr,       32'hC2C2C2C2);
        check("starve_hwait",   32'(hw),  32'd0);
        repeat (2) @(negedge clk);
        check("starve_idle", 32'(owner), 32'd3);

        // ---------------- Reset mid-ACCESS ----------------
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_owner",    32'(owner),    32'd3);
        check("mid_busy_rst", 32'(busy),     32'd0);
        check("mid_outs",     32'({mem_en, mem_we, if_ack, d_ack, h_ack}), 32'd0);
        check("mid_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rdata",    rdata,         32'd0);
        d_req = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (d_ack) dn++;
        end
        check("mid_no_ack", 32'(dn), 32'd0);
        d_req = 1'b1;
        wait_ack(1, 10, cyc);
        check("mid_reissue_lat",   32'(cyc), 32'd4);
        check("mid_reissue_rdata", rdata,    32'hA0A0A0A0);
        d_req = 1'b0;
        @(negedge clk);

        // ---------------- Byte enables ----------------
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0100; d_addr = 16'h0050; d_wdata = 32'hAABBCCDD;
        @(negedge clk);
        check("be_mem_en", 32'(mem_en), 32'd1);
        check("be_mem_we", 32'(mem_we), 32'b0100);
        wait_ack(1, 10, cyc);
        check("be_ack_lat", 32'(cyc), 32'd3);
        d_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_be = 4'b0000; d_wdata = 32'h55667788;
        @(negedge clk);
        check("be0_mem_en", 32'(mem_en), 32'd1);
        check("be0_mem_we", 32'(mem_we), 32'd0);
        wait_ack(1, 10, cyc);
        check("be0_ack_lat", 32'(cyc), 32'd3);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0050;
        wait_ack(2, 10, cyc);
        check("be_read_lat",  32'(cyc), 32'd4);
        check("be_read_data", rdata,    32'h11BB3344);
        h_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
